// File: rtl/conv_frame_sink.sv
// conv_frame_sink: collects one D x D frame of conv-stage pixels in raster
// order, then drains it over a valid/ready stream with end-of-row and
// end-of-frame markers. The buffer is single: it refills only after a full drain.
module conv_frame_sink #(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_eol,
  output logic                  rd_eof,
  output logic                  frame_done,
  output logic                  drain_done,
  output logic                  overflow
);

  localparam int FRAME = D * D;
  // Memory index width; the upper pointer bits only matter for the end-of-frame compares.
  localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(D - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  // Set once pixel FRAME-1 has been fetched, so rd_ptr never has to hold FRAME.
  logic                    fetch_all_q, fetch_all_d;
  // A memory read issued last cycle; its data is in rdata_q now.
  logic                    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  // Output stage: out_q is the presented beat, skid_q holds a second beat.
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  // Index of the beat presented in out_q, plus its column within the row.
  logic [ADDR_WIDTH-1:0]   beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic                    frame_done_q, frame_done_d;
  logic                    drain_done_q, drain_done_d;
  logic                    overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0]   mem_q [0:FRAME-1];

  logic                    wr_en_s;
  logic                    fetch_s;
  logic                    accept_s;
  logic                    last_beat_s;
  logic [2:0]              occ_s;

  assign rd_valid   = (cnt_q != 2'd0);
  assign rd_data    = out_q;
  assign rd_eol     = rd_valid && (col_q == LAST_COL);
  assign rd_eof     = rd_valid && (beat_q == LAST_ADDR);
  assign frame_done = frame_done_q;
  assign drain_done = drain_done_q;
  assign overflow   = overflow_q;

  assign wr_en_s     = (state_q == ST_FILL) && valid_in && !reset;
  assign accept_s    = rd_valid && rd_ready;
  assign last_beat_s = accept_s && (beat_q == LAST_ADDR);
  // Beats the output stage will hold once this cycle settles: held + arriving - leaving.
  assign occ_s       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, accept_s};
  assign fetch_s     = (state_q == ST_DRAIN) && !fetch_all_q && (occ_s < 3'd2);

  // Frame buffer write port and 1-cycle-latency read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= pxl_in;
    end
    if (fetch_s) begin
      rdata_q <= mem_q[rd_ptr_q[IDX_W-1:0]];
    end
  end

  // Control and output-stage registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fetch_all_q  <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
      out_q        <= '0;
      skid_q       <= '0;
      beat_q       <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      drain_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_all_q  <= fetch_all_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      beat_q       <= beat_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      drain_done_q <= drain_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic: capture in FILL, fetch/stage/hand off beats in DRAIN.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_all_d  = fetch_all_q;
    inflight_d   = 1'b0;
    cnt_d        = cnt_q;
    out_d        = out_q;
    skid_d       = skid_q;
    beat_d       = beat_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    drain_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      ST_FILL: begin
        if (valid_in) begin
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d     = '0;
            state_d      = ST_DRAIN;
            frame_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end

      ST_DRAIN: begin
        // Pixels arriving while the buffer is busy are dropped and flagged.
        if (valid_in) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end

        inflight_d = fetch_s;
        if (fetch_s) begin
          if (rd_ptr_q == LAST_ADDR) begin
            fetch_all_d = 1'b1;
            rd_ptr_d    = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end

        // Output stage: push = read data arriving, pop = beat accepted.
        case (cnt_q)
          2'd0: begin
            if (inflight_q) begin
              out_d = rdata_q;
              cnt_d = 2'd1;
            end else begin
              cnt_d = 2'd0;
            end
          end
          2'd1: begin
            if (accept_s && inflight_q) begin
              out_d = rdata_q;
            end else if (accept_s) begin
              cnt_d = 2'd0;
            end else if (inflight_q) begin
              skid_d = rdata_q;
              cnt_d  = 2'd2;
            end else begin
              cnt_d = 2'd1;
            end
          end
          2'd2: begin
            if (accept_s) begin
              out_d = skid_q;
              if (inflight_q) begin
                skid_d = rdata_q;
              end else begin
                cnt_d = 2'd1;
              end
            end else begin
              cnt_d = 2'd2;
            end
          end
          default: begin
            cnt_d = 2'd0;
          end
        endcase

        if (accept_s) begin
          beat_d = beat_q + ADDR_WIDTH'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
          end else begin
            col_d = col_q + ADDR_WIDTH'(1);
          end
        end else begin
          beat_d = beat_q;
        end

        // Last beat gone: rewind everything and reopen the buffer for capture.
        if (last_beat_s) begin
          state_d      = ST_FILL;
          rd_ptr_d     = '0;
          fetch_all_d  = 1'b0;
          inflight_d   = 1'b0;
          cnt_d        = 2'd0;
          beat_d       = '0;
          col_d        = '0;
          drain_done_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_frame_sink.sv
// tb_conv_frame_sink: randomized frames and backpressure against a frame-level
// reference model; expected beats are queued at frame completion and checked
// by the output monitor as they are accepted.
module tb_conv_frame_sink;

  localparam int D     = 4;
  localparam int FRAME = D * D;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          rd_ready = 1'b1;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_eol, rd_eof, frame_done, drain_done, overflow;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  // Reference model state.
  logic [DW-1:0] m_frame[$];
  logic [DW-1:0] exp_q[$];
  bit            armed = 1'b0, m_fill = 1'b1, m_ovf = 1'b0;
  bit            exp_fd = 1'b0, exp_dd = 1'b0, after_rst = 1'b0, prev_stall = 1'b0;
  bit            next_fd, next_dd;
  int            m_beats = 0, lat = 0;
  logic [DW-1:0] prev_data, mon_e;
  logic          prev_eol, prev_eof;

  conv_frame_sink #(.D(D), .DATA_WIDTH(DW), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_eol(rd_eol), .rd_eof(rd_eof), .frame_done(frame_done),
    .drain_done(drain_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream readiness: always ready, or a fair coin per cycle.
  always @(posedge clk) begin
    #1;
    rd_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Model + monitor: sample on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      armed = 1'b1; m_fill = 1'b1; m_ovf = 1'b0; exp_fd = 1'b0; exp_dd = 1'b0;
      after_rst = 1'b1; prev_stall = 1'b0; m_beats = 0; lat = 0;
      m_frame.delete(); exp_q.delete();
    end else if (armed) begin
      next_fd = 1'b0;
      next_dd = 1'b0;
      if (after_rst) begin
        chk1("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, '0);
        after_rst = 1'b0;
      end
      chk1("frame_done", frame_done, exp_fd);
      chk1("drain_done", drain_done, exp_dd);
      chk1("overflow", overflow, m_ovf);
      if (exp_dd) chk1("valid_after_drain", rd_valid, 1'b0);
      if (lat > 0) begin
        chk1("first_valid_latency", rd_valid, lat == 3);
        lat = (lat == 3) ? 0 : lat + 1;
      end
      if (prev_stall) begin
        chk1("stall_valid", rd_valid, 1'b1);
        chk("stall_data", rd_data, prev_data);
        chk1("stall_eol", rd_eol, prev_eol);
        chk1("stall_eof", rd_eof, prev_eof);
      end
      // Input side: capture in FILL, otherwise the pixel is an overflow.
      if (valid_in) begin
        if (m_fill) begin
          m_frame.push_back(pxl_in);
          if (m_frame.size() == FRAME) begin
            exp_q = m_frame;
            m_frame.delete();
            m_fill = 1'b0;
            next_fd = 1'b1;
            lat = 1;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      // Output side: every accepted beat must be the next pixel of the frame.
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", rd_data, mon_e);
          chk1("rd_eol", rd_eol, (m_beats % D) == D - 1);
          chk1("rd_eof", rd_eof, m_beats == FRAME - 1);
          m_beats++;
          if (m_beats == FRAME) begin
            m_beats = 0;
            m_fill = 1'b1;
            next_dd = 1'b1;
          end
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_eol = rd_eol;
      prev_eof = rd_eof;
      exp_fd = next_fd;
      exp_dd = next_dd;
    end
  end

  // Send count pixels (base+i or random) with 0..maxgap idle cycles before each.
  task automatic send_frame(input int base, input bit rnd, input int maxgap, input int count);
    for (int i = 0; i < count; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
      end
      @(posedge clk); #1;
      valid_in = 1'b1;
      pxl_in = rnd ? DW'($urandom) : DW'(base + i);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(m_fill && m_frame.size() == 0 && exp_q.size() == 0 && !exp_dd) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected drain complete", n);
    end
  endtask

  task automatic pulse_reset();
    #1;
    reset = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back frame 1..16, always ready.
    rnd_ready = 1'b0;
    send_frame(1, 1'b0, 0, FRAME);
    wait_idle(200);

    // Random data with random gaps.
    send_frame(0, 1'b1, 5, FRAME);
    wait_idle(300);

    // Random backpressure.
    rnd_ready = 1'b1;
    send_frame(1, 1'b0, 0, FRAME);
    wait_idle(300);

    // Overflow during drain, then a fresh frame.
    rnd_ready = 1'b0;
    send_frame(1, 1'b0, 0, FRAME);
    @(posedge clk); #1;
    valid_in = 1'b1;
    pxl_in = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1 valid_in = 1'b0;
    wait_idle(200);
    send_frame(0, 1'b1, 2, FRAME);
    wait_idle(300);

    // Reset after 7 writes, then 101..116.
    send_frame(900, 1'b0, 1, 7);
    @(posedge clk);
    pulse_reset();
    send_frame(101, 1'b0, 1, FRAME);
    wait_idle(300);

    // Reset mid-drain after 5 beats, then a full frame under backpressure.
    send_frame(1, 1'b0, 0, FRAME);
    n = 0;
    while (m_beats < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL mid_drain_wait: got timeout expected 5 beats");
    end
    pulse_reset();
    rnd_ready = 1'b1;
    send_frame(201, 1'b0, 0, FRAME);
    wait_idle(300);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
